alu_logic_arbiter: RTL

Round-robin arbiter and sequencer sharing one `alu_logic` instance among `NUM_REQ` independent requesters. It accepts one request at a time over a valid/ready handshake and latches its operands and opcode. It drives the shared logic unit from those registers, captures the result, flags and an illegal-opcode error, and holds a tagged response until the consumer accepts it. It sits between the issue ports and the single logic-unit datapath.

---
 rtl/alu_logic_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_logic_arbiter.sv
// Round-robin arbiter and sequencer sharing one alu_logic datapath among NUM_REQ issue ports.
// Accepts one request at a time, runs it on the shared unit and holds a tagged response.
package alu_logic_arbiter_pkg;
    localparam int unsigned OP_W = 4;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1111;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

module alu_logic_arbiter
    import alu_logic_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*OP_W-1:0]  req_op_i,
    output logic [WIDTH-1:0]         alu_a_o,
    output logic [WIDTH-1:0]         alu_b_o,
    output logic [OP_W-1:0]          alu_op_o,
    input  logic [WIDTH-1:0]         alu_result_i,
    input  logic                     alu_carry_i,
    input  logic                     alu_overflow_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]         rsp_result_o,
    output logic                     rsp_carry_o,
    output logic                     rsp_overflow_o,
    output logic                     rsp_err_o,
    output logic [STAT_W-1:0]        stat_ops_o
);

    localparam int unsigned IDX_W = ID_W + 1;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [STAT_W-1:0]  stat_q, stat_d;

    logic               gnt_vld_c;
    logic [ID_W-1:0]    gnt_idx_c;
    logic [WIDTH-1:0]   sel_a_c;
    logic [WIDTH-1:0]   sel_b_c;
    logic [OP_W-1:0]    sel_op_c;

    // First valid requester at or after rr_q, searching with wrap-around.
    always_comb begin : p_arb
        logic [IDX_W-1:0] cand;
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'(rr_q) + IDX_W'(k);
            if (cand >= IDX_W'(NUM_REQ)) begin
                cand = cand - IDX_W'(NUM_REQ);
            end
            if (!gnt_vld_c && req_valid_i[cand[ID_W-1:0]]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = cand[ID_W-1:0];
            end
        end
    end

    // Payload of the winning slice.
    always_comb begin : p_sel
        sel_a_c  = '0;
        sel_b_c  = '0;
        sel_op_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx_c == ID_W'(i)) begin
                sel_a_c  = req_a_i[i*WIDTH +: WIDTH];
                sel_b_c  = req_b_i[i*WIDTH +: WIDTH];
                sel_op_c = req_op_i[i*OP_W +: OP_W];
            end
        end
    end

    // Grant is only offered while idle and out of reset.
    always_comb begin : p_ready
        req_ready_o = '0;
        if (rst_n && (state_q == ST_IDLE) && gnt_vld_c) begin
            req_ready_o[gnt_idx_c] = 1'b1;
        end
    end

    always_comb begin : p_next
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        stat_d      = stat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld_c) begin
                    a_d     = sel_a_c;
                    b_d     = sel_b_c;
                    op_d    = sel_op_c;
                    id_d    = gnt_idx_c;
                    rr_d    = (gnt_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Unsupported opcode masks whatever the shared unit produced.
                err_d       = (op_q == OP_ILLEGAL);
                res_d       = err_d ? '0 : alu_result_i;
                carry_d     = err_d ? 1'b0 : alu_carry_i;
                ovf_d       = err_d ? 1'b0 : alu_overflow_i;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    stat_d  = stat_q + STAT_W'(1);
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            stat_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            stat_q      <= stat_d;
        end
    end

    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;
    assign alu_op_o       = op_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_id_o       = id_q;
    assign rsp_result_o   = res_q;
    assign rsp_carry_o    = carry_q;
    assign rsp_overflow_o = ovf_q;
    assign rsp_err_o      = err_q;
    assign stat_ops_o     = stat_q;

endmodule
